// File: rtl/ram_sdp_init.sv
// rtl/ram_sdp_init.sv - simple-dual-port byte-lane RAM with registered read and clear-on-reset sequencer
module ram_sdp_init #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                    BYPASS     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [DATA_WIDTH/8-1:0]   wbe,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rvalid,
  output logic                      init_busy
);

  localparam int                    DEPTH   = 2 ** ADDR_WIDTH;
  localparam int                    NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;

  // The clear sequencer borrows the single write port while in CLEAR.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = data_in;
    wr_be   = wbe;
    rd_en   = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_q;
        wr_data = INIT_VALUE;
        wr_be   = '1;
        if (&clr_ptr_q) state_d = READY;
      end
      READY: begin
        wr_en = we;
        rd_en = re;
      end
      default: state_d = CLEAR;
    endcase
    if (rst) begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      state_d = CLEAR;
    end
  end

  // Same-address bypass merges only the enabled lanes of the incoming word.
  always_comb begin
    rd_word = mem[raddr];
    for (int i = 0; i < NB; i++) begin
      if (BYPASS && we && wbe[i] && (waddr == raddr))
        rd_word[i*8 +: 8] = data_in[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && wr_be[i])
        mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      data_out  <= '0;
      rvalid    <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      if (state_q == CLEAR) clr_ptr_q <= clr_ptr_q + PTR_ONE;
      init_busy <= (state_d == CLEAR);
      rvalid    <= rd_en;
      if (rd_en) data_out <= rd_word;
    end
  end

endmodule
